// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request per PC value,
// hands the returned word to decode with PC+4, and pulses PCWrite once per
// accepted instruction. Redirects (Flush) discard in-flight data; a request
// left unacknowledged for TIMEOUT cycles parks the unit in a sticky error state.
module fetch_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCResult,
  output logic        PCWrite,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  input  logic        Stall,
  input  logic        Flush,
  output logic [31:0] InstrOut,
  output logic [31:0] PCPlus4Out,
  output logic        InstrValid,
  output logic        FetchErr
);

  // Counter is wide enough to hold TIMEOUT; a TIMEOUT below 1 is treated as 1.
  localparam int TIMEOUT_EFF = (TIMEOUT < 1) ? 1 : TIMEOUT;
  localparam int CNT_W       = $clog2(TIMEOUT_EFF + 1);
  // Value of the counter during the last unacknowledged cycle that is still tolerated.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_EFF - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    VALID = 3'd2,
    DROP  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;

  // Fetch FSM with all outputs registered alongside the state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      PCWrite    <= 1'b0;
      IMemReq    <= 1'b0;
      IMemAddr   <= 32'd0;
      InstrOut   <= 32'd0;
      PCPlus4Out <= 32'd0;
      InstrValid <= 1'b0;
      FetchErr   <= 1'b0;
    end else begin
      // PCWrite is only ever raised on the FETCH->VALID edge, so it drops
      // again after exactly one cycle.
      PCWrite <= 1'b0;
      case (state_reg)
        IDLE: begin
          state_reg <= FETCH;
          IMemAddr  <= PCResult;
          IMemReq   <= 1'b1;
          count_reg <= '0;
        end

        FETCH: begin
          if (IMemAck) begin
            count_reg <= '0;
            if (Flush) begin
              // Redirect arrived with the data: drop it and refetch at once.
              IMemAddr  <= PCResult;
              state_reg <= FETCH;
            end else begin
              InstrOut   <= IMemData;
              PCPlus4Out <= IMemAddr + 32'd4;
              InstrValid <= 1'b1;
              PCWrite    <= 1'b1;
              IMemReq    <= 1'b0;
              state_reg  <= VALID;
            end
          end else if (count_reg == LAST_CNT) begin
            // Timeout wins over a simultaneous flush; memory is considered dead.
            IMemReq   <= 1'b0;
            FetchErr  <= 1'b1;
            state_reg <= ERR;
          end else if (Flush) begin
            // Request cannot be withdrawn; wait for its ack and discard it.
            count_reg <= '0;
            state_reg <= DROP;
          end else begin
            count_reg <= count_reg + CNT_W'(1);
          end
        end

        DROP: begin
          if (IMemAck) begin
            IMemAddr  <= PCResult;
            count_reg <= '0;
            state_reg <= FETCH;
          end else if (count_reg == LAST_CNT) begin
            IMemReq   <= 1'b0;
            FetchErr  <= 1'b1;
            state_reg <= ERR;
          end else begin
            count_reg <= count_reg + CNT_W'(1);
          end
        end

        VALID: begin
          // Flush beats Stall; otherwise a non-stalled cycle consumes the word.
          if (Flush || !Stall) begin
            InstrValid <= 1'b0;
            state_reg  <= IDLE;
          end
        end

        ERR: begin
          IMemReq    <= 1'b0;
          InstrValid <= 1'b0;
          FetchErr   <= 1'b1;
        end

        default: begin
          state_reg <= IDLE;
          IMemReq   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs change and outputs are checked 1ns
// after each rising edge, against hand-computed values.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PCResult;
  logic        PCWrite;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemData;
  logic        Stall;
  logic        Flush;
  logic [31:0] InstrOut;
  logic [31:0] PCPlus4Out;
  logic        InstrValid;
  logic        FetchErr;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_unit #(.TIMEOUT(15)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .PCResult   (PCResult),
    .PCWrite    (PCWrite),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemAck    (IMemAck),
    .IMemData   (IMemData),
    .Stall      (Stall),
    .Flush      (Flush),
    .InstrOut   (InstrOut),
    .PCPlus4Out (PCPlus4Out),
    .InstrValid (InstrValid),
    .FetchErr   (FetchErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-22s got=%08h exp=%08h ok", tag, got, exp);
    end else begin
      $display("FAIL %-22s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Checks the handshake/status outputs in one call.
  task automatic check_ctl(input string tag, input logic req, input logic pcw,
                           input logic vld, input logic err);
    check({tag, ".req"}, {31'd0, IMemReq},    {31'd0, req});
    check({tag, ".pcw"}, {31'd0, PCWrite},    {31'd0, pcw});
    check({tag, ".vld"}, {31'd0, InstrValid}, {31'd0, vld});
    check({tag, ".err"}, {31'd0, FetchErr},   {31'd0, err});
  endtask

  task automatic check_all_zero(input string tag);
    check_ctl(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, ".addr"}, IMemAddr,   32'd0);
    check({tag, ".ins"},  InstrOut,   32'd0);
    check({tag, ".pc4"},  PCPlus4Out, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; PCResult = 32'd0; IMemAck = 1'b0; IMemData = 32'd0;
    Stall = 1'b0; Flush = 1'b0;
    tick(); tick();
    check_all_zero("reset");

    // Zero-latency fetch at 0x40.
    Reset = 1'b0; PCResult = 32'h40; IMemAck = 1'b1; IMemData = 32'h8C220004;
    tick();
    check_ctl("fetch40", 1'b1, 1'b0, 1'b0, 1'b0);
    check("fetch40.addr", IMemAddr, 32'h40);
    tick();
    check_ctl("valid40", 1'b0, 1'b1, 1'b1, 1'b0);
    check("valid40.ins", InstrOut, 32'h8C220004);
    check("valid40.pc4", PCPlus4Out, 32'h44);

    // Stall across three VALID cycles.
    IMemAck = 1'b0; IMemData = 32'h0; Stall = 1'b1;
    tick();
    check_ctl("stall2", 1'b0, 1'b0, 1'b1, 1'b0);
    check("stall2.ins", InstrOut, 32'h8C220004);
    tick();
    check_ctl("stall3", 1'b0, 1'b0, 1'b1, 1'b0);
    check("stall3.ins", InstrOut, 32'h8C220004);
    Stall = 1'b0;
    tick();
    check_ctl("consumed", 1'b0, 1'b0, 1'b0, 1'b0);

    // Flush while request outstanding -> DROP, late ack discarded.
    PCResult = 32'h100;
    tick();
    check_ctl("fetch100", 1'b1, 1'b0, 1'b0, 1'b0);
    check("fetch100.addr", IMemAddr, 32'h100);
    Flush = 1'b1;
    tick();
    check_ctl("drop1", 1'b1, 1'b0, 1'b0, 1'b0);
    check("drop1.addr", IMemAddr, 32'h100);
    Flush = 1'b0; PCResult = 32'h200;
    tick();
    check_ctl("drop2", 1'b1, 1'b0, 1'b0, 1'b0);
    IMemAck = 1'b1; IMemData = 32'hDEADBEEF;
    tick();
    check_ctl("refetch", 1'b1, 1'b0, 1'b0, 1'b0);
    check("refetch.addr", IMemAddr, 32'h200);
    tick();
    check_ctl("valid200", 1'b0, 1'b1, 1'b1, 1'b0);
    check("valid200.ins", InstrOut, 32'hDEADBEEF);
    check("valid200.pc4", PCPlus4Out, 32'h204);
    IMemAck = 1'b0;
    tick();
    check_ctl("idle200", 1'b0, 1'b0, 1'b0, 1'b0);

    // Address wrap.
    PCResult = 32'hFFFFFFFC; IMemAck = 1'b1; IMemData = 32'h12345678;
    tick();
    check("wrap.addr", IMemAddr, 32'hFFFFFFFC);
    tick();
    check("wrap.pc4", PCPlus4Out, 32'h00000000);
    check("wrap.ins", InstrOut, 32'h12345678);
    IMemAck = 1'b0;
    tick();

    // Ack coinciding with Flush in FETCH: immediate refetch at new PC.
    PCResult = 32'h300;
    tick();
    check("fl_ack.addr0", IMemAddr, 32'h300);
    IMemAck = 1'b1; IMemData = 32'hBAD0BAD0; Flush = 1'b1; PCResult = 32'h400;
    tick();
    check_ctl("fl_ack", 1'b1, 1'b0, 1'b0, 1'b0);
    check("fl_ack.addr1", IMemAddr, 32'h400);
    Flush = 1'b0; IMemData = 32'h0000000A;
    tick();
    check("v400.ins", InstrOut, 32'h0000000A);
    check("v400.pc4", PCPlus4Out, 32'h404);
    // Flush beats Stall in VALID.
    IMemAck = 1'b0; Flush = 1'b1; Stall = 1'b1;
    tick();
    check_ctl("vflush", 1'b0, 1'b0, 1'b0, 1'b0);
    Flush = 1'b0; Stall = 1'b0;

    // Timeout: 15 unacknowledged FETCH cycles -> ERR.
    PCResult = 32'h500;
    tick();
    check_ctl("to.c1", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) tick();
    check_ctl("to.c15", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_ctl("to.err", 1'b0, 1'b0, 1'b0, 1'b1);
    IMemAck = 1'b1;
    tick(); tick(); tick();
    check_ctl("to.sticky", 1'b0, 1'b0, 1'b0, 1'b1);
    IMemAck = 1'b0; Reset = 1'b1;
    tick();
    check_all_zero("err_reset");

    // Reset abandons an outstanding request.
    Reset = 1'b0; PCResult = 32'h600;
    tick();
    check_ctl("mid.fetch", 1'b1, 1'b0, 1'b0, 1'b0);
    Reset = 1'b1;
    tick();
    check_all_zero("mid_reset");
    Reset = 1'b0; PCResult = 32'h700;
    tick();
    check_ctl("post_reset", 1'b1, 1'b0, 1'b0, 1'b0);
    check("post_reset.addr", IMemAddr, 32'h700);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter TIMEOUT, default 15, max cycles an instruction-memory request may stay unacknowledged.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 PCResult  input  32  current program-counter value from the PC register.
REQ-005 PCWrite  output  1  one-cycle pulse commanding the PC register to load its next address.
REQ-006 IMemReq  output  1  instruction-memory request valid.
REQ-007 IMemAddr  output  32  instruction-memory request address.
REQ-008 IMemAck  input  1  memory accepts the request and IMemData is valid this cycle.
REQ-009 IMemData  input  32  instruction word returned by memory.
REQ-010 Stall  input  1  decode stage cannot accept an instruction this cycle.
REQ-011 Flush  input  1  branch/jump redirect; current fetch is discarded.
REQ-012 InstrOut  output  32  fetched instruction to decode stage.
REQ-013 PCPlus4Out  output  32  fetch address + 4, paired with InstrOut.
REQ-014 InstrValid  output  1  InstrOut/PCPlus4Out hold a valid instruction.
REQ-015 FetchErr  output  1  sticky memory-timeout error flag.

Function
REQ-016 States SHALL be IDLE, FETCH, VALID, DROP, ERR; all outputs registered.
REQ-017 IDLE SHALL transition to FETCH unconditionally on the next edge, capturing IMemAddr <= PCResult.
REQ-018 In FETCH and DROP, IMemReq SHALL be 1 and IMemAddr SHALL remain stable; in all other states IMemReq SHALL be 0.
REQ-019 FETCH, IMemAck=1, Flush=0: InstrOut <= IMemData, PCPlus4Out <= IMemAddr + 4 (mod 2^32), InstrValid <= 1, PCWrite <= 1, next state VALID.
REQ-020 PCWrite SHALL be high for exactly one cycle (the first VALID cycle) per accepted instruction and never otherwise.
REQ-021 FETCH, IMemAck=1, Flush=1: data discarded, no PCWrite, IMemAddr <= PCResult, next state FETCH.
REQ-022 FETCH, IMemAck=0, Flush=1: next state DROP (request stays asserted until acknowledged).
REQ-023 DROP, IMemAck=1: data discarded, no PCWrite, IMemAddr <= PCResult, next state FETCH; Flush in DROP has no additional effect.
REQ-024 VALID, Flush=1: InstrValid <= 0, next state IDLE (Flush has priority over Stall).
REQ-025 VALID, Flush=0, Stall=1: InstrOut, PCPlus4Out, InstrValid held unchanged.
REQ-026 VALID, Flush=0, Stall=0: instruction consumed this edge; InstrValid <= 0, next state IDLE.
REQ-027 Timeout counter SHALL reset to 0 on entry to FETCH/DROP and increment each FETCH/DROP cycle with IMemAck=0.
REQ-028 When counter reaches TIMEOUT with IMemAck=0, next state SHALL be ERR; IMemAck in that same cycle takes priority over timeout.
REQ-029 ERR: FetchErr=1, IMemReq=0, InstrValid=0, PCWrite=0; held until Reset.
REQ-030 Zero-latency ack (IMemAck in first FETCH cycle) SHALL be supported; steady-state throughput 1 instruction per 3 cycles with Stall=0.

Reset
REQ-031 Reset=1 at a rising edge SHALL force state IDLE, IMemReq=0, IMemAddr=0, PCWrite=0, InstrValid=0, InstrOut=0, PCPlus4Out=0, FetchErr=0, counter=0, from any state including mid-request and ERR.
REQ-032 Reset SHALL take priority over all other inputs; a pending memory request is abandoned without completing.

Verification
REQ-033 Reset released, PCResult=0x40, IMemAck=1 first FETCH cycle, IMemData=0x8C220004 -> InstrOut=0x8C220004, PCPlus4Out=0x44, InstrValid=1, PCWrite pulse 1 cycle.
REQ-034 Stall=1 for 3 cycles in VALID -> InstrOut/InstrValid unchanged 3 cycles, no second PCWrite; Stall=0 -> InstrValid=0 next cycle.
REQ-035 Flush=1 in FETCH with IMemAck=0, ack 2 cycles later -> DROP entered, data discarded, no PCWrite, next request address = current PCResult.
REQ-036 IMemAck held 0, TIMEOUT=15 -> FetchErr=1 and IMemReq=0 after 15 unacknowledged cycles; stays until Reset, then all outputs 0.
REQ-037 PCResult=0xFFFFFFFC fetched -> PCPlus4Out=0x00000000 (wrap).
REQ-038 Reset=1 asserted mid-FETCH with IMemReq=1 -> next cycle IMemReq=0, state IDLE, all outputs at reset values.
